// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: RAM handshake/word types and the
// arbiter grant state encoding.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

package dp_types_pkg;
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} arb_state_t;
endpackage

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access paths.
// Data wins arbitration unless it has starved fetch for DSTREAK_MAX grants.
module mem_arbiter
  import cpu_types_pkg::*;
  import dp_types_pkg::*;
#(
  parameter int DSTREAK_MAX = 4
) (
  input  logic      CLK,
  input  logic      nRST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      ramerr
);

  localparam logic [3:0] STREAK_MAX = 4'(DSTREAK_MAX);

  arb_state_t state_q, state_d;
  logic [3:0] dstreak_q, dstreak_d;
  logic       ramerr_q, ramerr_d;
  logic       d_req;
  logic       ram_done;

  assign d_req    = dREN | dWEN;
  assign ram_done = (ramstate == ACCESS) || (ramstate == ERROR);
  assign ramerr   = ramerr_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      dstreak_q <= 4'd0;
      ramerr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
      ramerr_q  <= ramerr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    ramerr_d  = ramerr_q;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;

    case (state_q)
      IDLE: begin
        if (d_req && (!iREN || (dstreak_q < STREAK_MAX))) begin
          state_d = GRANT_D;
        end else if (iREN) begin
          state_d = GRANT_I;
        end
      end

      GRANT_I: begin
        // A dropped request aborts silently; the streak is left untouched.
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_done) begin
            iwait     = 1'b0;
            iload     = ramload;
            state_d   = IDLE;
            dstreak_d = 4'd0;
            if (ramstate == ERROR) ramerr_d = 1'b1;
          end
        end
      end

      GRANT_D: begin
        if (!d_req) begin
          state_d = IDLE;
        end else begin
          ramREN   = dREN;
          ramWEN   = dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ram_done) begin
            dwait   = 1'b0;
            dload   = ramload;
            state_d = IDLE;
            if (!iREN) begin
              dstreak_d = 4'd0;
            end else if (dstreak_q < STREAK_MAX) begin
              dstreak_d = dstreak_q + 4'd1;
            end
            if (ramstate == ERROR) ramerr_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction fetch path (icache side) and the data path (dcache side).
- Registers a grant per transaction and holds it until RAM reports ACCESS.
- Data requests have priority, so load/store stalls resolve first. A streak counter bounds instruction-fetch starvation.
- Sits between the cache/datapath request signals and the RAM model. It drives iwait/dwait, which the pipeline stall logic consumes.

Parameters:
- DSTREAK_MAX, 4: consecutive data grants allowed while iREN is pending before one instruction grant is forced. Legal range 1..15.

Ports:
- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- iwait  out  1  high while the instruction request is not yet completed
- iload  out  32  instruction read data, valid when iREN && !iwait
- dREN  in  1  data read request
- dWEN  in  1  data write request; dREN and dWEN are never both high
- daddr  in  32  data address
- dstore  in  32  data write value
- dwait  out  1  high while the data request is not yet completed
- dload  out  32  data read data, valid when dREN && !dwait
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- ramerr  out  1  sticky flag, set when any granted access ends in ERROR

Behaviour:
- Clock and reset: one clock, CLK. nRST is asynchronous and active-low.
- Reset values: state = IDLE, dstreak = 0, ramerr = 0. RAM strobes are 0, iwait = 1, dwait = 1, loads are 0.
- FSM states are IDLE, GRANT_I and GRANT_D. The state register is the only grant record.
- Arbitration in IDLE is evaluated combinationally and registered on the next edge:
  - dREN|dWEN and (!iREN or dstreak < DSTREAK_MAX) -> GRANT_D.
  - Otherwise, iREN -> GRANT_I.
  - Otherwise, stay in IDLE.
- IDLE drives no RAM strobes. Arbitration therefore costs exactly 1 cycle.
- In GRANT_x:
  - ramREN, ramWEN, ramaddr and ramstore are driven from the owner's live inputs.
  - The non-owner's wait stays high.
- Completion:
  - When ramstate == ACCESS in GRANT_x, the owner's wait is 0 in that same cycle (combinational).
  - xload = ramload in that cycle, and the next state is IDLE.
  - Minimum request-to-done latency is 2 cycles.
- ERROR in GRANT_x:
  - Treated as completion: wait = 0, load = ramload, next state IDLE.
  - ramerr is set and stays set until reset.
- FREE/BUSY in GRANT_x: the owner's wait stays high and the state is held.
- Owner drops its request while granted:
  - Abort: RAM strobes go to 0 in the same cycle.
  - Next state is IDLE. No ACK is generated and dstreak is unchanged.
- dstreak update (saturates at DSTREAK_MAX):
  - Increments on each GRANT_D completion while iREN is high.
  - Clears on each GRANT_I completion, or when iREN is low at a data completion.
- Simultaneous iREN and dREN in IDLE with dstreak == DSTREAK_MAX: the instruction request wins.
- Back-to-back requests: each completion returns to IDLE, so there is always 1 idle cycle between grants.
- Reset asserted mid-grant: immediately IDLE and strobes low. No partial ACK; any in-flight RAM access is discarded.
- Outputs not driven by a grant hold their reset values:
  - Wait outputs are always 1 unless a completion is occurring.
  - Loads are 0.

Decomposition:
- ramstate_t and word_t come from cpu_types_pkg.
- Add arb_state_t (IDLE, GRANT_I, GRANT_D) to dp_types_pkg.
- No sub-module: the FSM, streak counter and output mux form one module of roughly 150-200 lines.

Test Plan:
- Reset with iREN = 1: hold nRST low for 2 cycles, then release. iwait stays 1, ramREN = 0 during reset, and ramREN = 1 with ramaddr = iaddr on cycle 2 after release.
- Solo fetch: iREN = 1, iaddr = 0x0000_0040, ramstate goes BUSY, BUSY, ACCESS with ramload = 0x2001_0005. iwait = 0 and iload = 0x2001_0005 only in the ACCESS cycle; the state is IDLE the next cycle.
- Simultaneous requests: iREN = 1 and dWEN = 1 with daddr = 0x100 and dstore = 0xDEAD_BEEF. ramWEN is granted first and ramstore = 0xDEAD_BEEF. The instruction is granted after the data ACCESS plus 1 idle cycle.
- Starvation bound: DSTREAK_MAX = 4, iREN held, dREN re-asserted continuously. Exactly 4 data completions occur, then 1 instruction completion, then data resumes.
- Abort: grant D, then drop dREN while ramstate = BUSY. ramREN = 0 in the same cycle, no dwait = 0 pulse, and the pending iREN is granted next.
- Error: ramstate = ERROR during GRANT_I. iwait = 0 that cycle, ramerr = 1 and stays 1 through later ACCESS completions until nRST.
